// File: rtl/bm_if_sched.sv
// bm_if_sched: round-robin scheduler sharing one bitwise ALU among four requesters
//   clock, reset         : rising-edge clock, synchronous active-high reset
//   req[3:0]             : per-requester request
//   op_a, op_b           : packed operands, requester i at [i*BITS +: BITS]
//   op_sel[7:0]          : packed op codes, requester i at [2i +: 2]
//   gnt[3:0]             : one-hot grant while an operation is in flight
//   res_valid            : one-cycle pulse with res_id/res_data of a completed op
//   busy                 : high outside IDLE
//   op_count[7:0]        : completed operations, saturating at 255
module bm_if_sched #(
    parameter int BITS = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        req,
    input  logic [4*BITS-1:0] op_a,
    input  logic [4*BITS-1:0] op_b,
    input  logic [7:0]        op_sel,
    output logic [3:0]        gnt,
    output logic              res_valid,
    output logic [1:0]        res_id,
    output logic [BITS-1:0]   res_data,
    output logic              busy,
    output logic [7:0]        op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t          r_state, w_next;
    logic [1:0]      r_ptr, w_win, r_op, r_id;
    logic [BITS-1:0] r_a, r_b, r_data, w_alu;
    logic [7:0]      r_cnt;
    // r_ptr doubles as the current winner once granted, since it is updated on the grant.
    // Scanning from the farthest offset down lets the nearest requester after r_ptr win.
    always_comb begin
        w_win = r_ptr;
        for (int k = 4; k >= 1; k--)
            if (req[r_ptr + 2'(k)]) w_win = r_ptr + 2'(k);
    end
    always_comb w_alu = r_op == 2'd0 ? '0 : r_op == 2'd1 ? r_a & r_b : r_op == 2'd2 ? r_a | r_b : r_a ^ r_b;
    always_ff @(posedge clock) r_state <= reset ? IDLE : w_next;
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = |req ? EXEC : IDLE;
            EXEC:    w_next = req[r_ptr] ? DONE : IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr  <= 2'd3;
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= '0;
            r_id   <= '0;
            r_data <= '0;
            r_cnt  <= '0;
        end else if (r_state == IDLE && |req) begin
            r_ptr <= w_win;
            r_a   <= op_a[w_win*BITS +: BITS];
            r_b   <= op_b[w_win*BITS +: BITS];
            r_op  <= op_sel[w_win*2 +: 2];
        end else if (r_state == EXEC && req[r_ptr]) begin
            r_data <= w_alu;
            r_id   <= r_ptr;
            r_cnt  <= r_cnt + 8'(r_cnt != 8'hFF);
        end
    end
    always_comb begin
        busy      = r_state != IDLE;
        gnt       = busy ? 4'b0001 << r_ptr : 4'b0000;
        res_valid = r_state == DONE;
    end
    assign res_id   = r_id;
    assign res_data = r_data;
    assign op_count = r_cnt;
endmodule

// File: tb/tb_bm_if_sched.sv
// tb_bm_if_sched: scoreboard bench for bm_if_sched
module tb_bm_if_sched;
    localparam int BITS = 2;
    typedef struct {
        logic [1:0]      id;
        logic [BITS-1:0] data;
    } exp_t;
    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [3:0]        req = '0;
    logic [4*BITS-1:0] op_a = '0;
    logic [4*BITS-1:0] op_b = '0;
    logic [7:0]        op_sel = '0;
    logic [3:0]        gnt;
    logic              res_valid;
    logic [1:0]        res_id;
    logic [BITS-1:0]   res_data;
    logic              busy;
    logic [7:0]        op_count;
    int                errors = 0;
    int                checks = 0;
    int                m_ptr = 3;
    int                exp_cnt = 0;
    logic [BITS-1:0]   last_data = '0;
    bit                mon_en = 1'b0;
    exp_t              sbq[$];
    exp_t              e_mon;

    bm_if_sched #(.BITS(BITS)) dut (
        .clock(clock), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
        .gnt(gnt), .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
        .busy(busy), .op_count(op_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BITS-1:0] alu(input logic [BITS-1:0] a, input logic [BITS-1:0] b, input logic [1:0] s);
        case (s)
            2'd0:    return '0;
            2'd1:    return a & b;
            2'd2:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic int pick(input logic [3:0] r);
        for (int k = 1; k <= 4; k++)
            if (r[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        return -1;
    endfunction

    task automatic set_op(input int i, input logic [BITS-1:0] a, input logic [BITS-1:0] b, input logic [1:0] s);
        op_a[i*BITS +: BITS] = a;
        op_b[i*BITS +: BITS] = b;
        op_sel[i*2 +: 2]     = s;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset   = 1'b0;
        m_ptr   = 3;
        exp_cnt = 0;
        last_data = '0;
        sbq.delete();
    endtask

    task automatic push_exp(input logic [3:0] r, output int w);
        exp_t e;
        w      = pick(r);
        e.id   = 2'(w);
        e.data = alu(op_a[w*BITS +: BITS], op_b[w*BITS +: BITS], op_sel[w*2 +: 2]);
        sbq.push_back(e);
        m_ptr  = w;
    endtask

    task automatic run_op(input logic [3:0] r);
        int w;
        req = r;
        push_exp(r, w);
        @(posedge clock); #1;
        check("gnt_grant", gnt, 4'b0001 << w);
        check("busy_exec", busy, 1);
        check("valid_early", res_valid, 0);
        @(posedge clock); #1;
        check("gnt_hold", gnt, 4'b0001 << w);
        check("valid_pulse", res_valid, 1);
        @(posedge clock); #1;
        check("gnt_release", gnt, 0);
        check("busy_idle", busy, 0);
        check("valid_end", res_valid, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt"}, gnt, 0);
        check({tag, "_valid"}, res_valid, 0);
        check({tag, "_id"}, res_id, 0);
        check({tag, "_data"}, res_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cnt"}, op_count, 0);
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            check("gnt_onehot", 32'($countones(gnt) <= 1), 1);
            if (res_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e_mon   = sbq.pop_front();
                    exp_cnt = exp_cnt < 255 ? exp_cnt + 1 : 255;
                    check("res_id", res_id, e_mon.id);
                    check("res_data", res_data, e_mon.data);
                    check("op_count", op_count, exp_cnt);
                    last_data = e_mon.data;
                end
            end
        end
    end

    initial begin
        int w;
        do_reset();
        mon_en = 1'b1;
        check_zero("reset");
        set_op(0, 2'b11, 2'b10, 2'b01);
        run_op(4'b0001);
        check("op_count_one", op_count, 1);
        req = '0;
        set_op(2, 2'b01, 2'b11, 2'b11);
        run_op(4'b0100);
        set_op(2, 2'b01, 2'b11, 2'b00);
        run_op(4'b0100);
        req = 4'b0010;
        m_ptr = 1;
        @(posedge clock); #1;
        check("cancel_gnt", gnt, 4'b0010);
        req = '0;
        @(posedge clock); #1;
        check("cancel_gnt_off", gnt, 0);
        check("cancel_busy", busy, 0);
        check("cancel_valid", res_valid, 0);
        check("cancel_data", res_data, last_data);
        check("cancel_cnt", op_count, exp_cnt);
        for (int i = 0; i < 4; i++) set_op(i, 2'($urandom), 2'($urandom), 2'($urandom));
        run_op(4'b1111);
        check("after_cancel_winner", res_id, 2);
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, 2'($urandom), 2'($urandom), 2'($urandom));
        for (int n = 0; n < 5; n++) run_op(4'b1111);
        check("rr_count5", op_count, 5);
        do_reset();
        set_op(0, 2'b11, 2'b01, 2'b10);
        req = 4'b0001;
        @(posedge clock); #1;
        reset = 1'b1;
        req   = '0;
        @(posedge clock); #1;
        reset = 1'b0;
        m_ptr = 3;
        check_zero("rst_exec");
        req = 4'b0001;
        push_exp(4'b0001, w);
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        req   = '0;
        m_ptr = 3;
        exp_cnt = 0;
        check_zero("rst_done");
        set_op(3, 2'b10, 2'b11, 2'b01);
        run_op(4'b1001);
        check("rst_done_winner", res_id, 0);
        do_reset();
        set_op(0, 2'b10, 2'b01, 2'b10);
        for (int n = 0; n < 300; n++) run_op(4'b0001);
        check("sat_255", op_count, 255);
        req = '0;
        @(posedge clock); #1;
        check("sat_hold", op_count, 255);
        check("sb_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bm_if_sched.md
BM_IF_SCHED -- requirements
Module: bm_if_sched

Interface
REQ-001 SHALL have parameter BITS, default 2, giving the operand/result width in bits.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on the clock rising edge.
REQ-004 SHALL have port req  input  4  per-requester request, bit i = requester i.
REQ-005 SHALL have port op_a  input  4*BITS  operand A, requester i at bits [i*BITS +: BITS].
REQ-006 SHALL have port op_b  input  4*BITS  operand B, same packing as op_a.
REQ-007 SHALL have port op_sel  input  8  operation code, requester i at bits [2i +: 2].
REQ-008 SHALL have port gnt  output  4  one-hot grant to the current winner; all-zero when none.
REQ-009 SHALL have port res_valid  output  1  one-cycle pulse marking a completed result.
REQ-010 SHALL have port res_id  output  2  index of the requester owning res_data.
REQ-011 SHALL have port res_data  output  BITS  registered result of the shared datapath.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port op_count  output  8  count of completed (res_valid) operations, saturating at 255.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, EXEC, DONE.
REQ-015 IDLE: req sampled only in this state; if any req bit is high, SHALL select the winner, set gnt one-hot, latch the winner's op_a/op_b/op_sel slices and go to EXEC; otherwise stay in IDLE with gnt=0.
REQ-016 Winner selection SHALL be round-robin: search order ptr+1, ptr+2, ptr+3, ptr (mod 4), where ptr = index of the last granted requester.
REQ-017 ptr SHALL update to the winner index on the IDLE->EXEC transition.
REQ-018 EXEC: SHALL hold gnt, compute the latched op into res_data and go to DONE next cycle.
REQ-019 Op decode SHALL be: 00 -> all zeros; 01 -> A & B; 10 -> A | B; 11 -> A ^ B; width BITS, no carry.
REQ-020 Cancel: if req[winner] is low during EXEC, SHALL skip DONE, return to IDLE with gnt=0, keep res_data unchanged, not pulse res_valid, not increment op_count; ptr remains advanced.
REQ-021 DONE: SHALL assert res_valid for exactly this cycle with res_id=winner, hold gnt, increment op_count (saturate at 255), and go to IDLE next cycle.
REQ-022 Latency: req high at IDLE edge N -> gnt high from N+1 to N+2 inclusive, res_valid high in cycle N+2, IDLE again at N+3.
REQ-023 Requests arriving or changing in EXEC or DONE SHALL be ignored until the next IDLE cycle; one operation per 3 cycles maximum.
REQ-024 res_data and res_id SHALL hold their last values between res_valid pulses.
REQ-025 gnt SHALL never have more than one bit set.

Reset
REQ-026 reset high SHALL force, on the next rising edge and regardless of state: state=IDLE, gnt=0, res_valid=0, res_id=0, res_data=0, busy=0, op_count=0, ptr=3 (requester 0 highest priority first).
REQ-027 reset asserted mid-operation (EXEC or DONE) SHALL abort it with no res_valid pulse and no op_count change.

Verification
REQ-028 After reset, req=4'b0001, op_sel[1:0]=01, A0=2'b11, B0=2'b10 -> gnt=0001 for 2 cycles, res_valid one cycle later than gnt rise, res_id=0, res_data=2'b10, op_count=1.
REQ-029 req=4'b1111 held constant from reset -> grant order 0,1,2,3,0 at 3-cycle spacing, op_count=5 after 15 cycles.
REQ-030 Requester 2 only, op_sel=11, A=2'b01, B=2'b11 -> res_data=2'b10; then op_sel=00 -> res_data=2'b00.
REQ-031 req[1] granted, dropped during EXEC -> no res_valid, res_data unchanged, op_count unchanged, next IDLE grant search starts at 2.
REQ-032 reset pulsed during DONE -> res_valid=0 that cycle onward, all outputs zero, next request from 4'b1000 and 4'b0001 both set grants requester 0.
REQ-033 300 completed ops back-to-back -> op_count stops at 255 and holds.
